// File: rtl/wbu_pkg.sv
// Shared writeback constants: register-file geometry, load size encodings and
// source-select encoding used by the LSU, decode and writeback unit.
package wbu_pkg;

  localparam int unsigned WBU_DATA_W = 32;
  localparam int unsigned GPRS_WIDTH = 5;
  localparam int unsigned NUM_GPRS   = 32;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'd0,
    LSU_SIZE_H = 2'd1,
    LSU_SIZE_W = 2'd2
  } lsu_size_e;

  typedef enum logic {
    WBU_SRC_EXU = 1'b0,
    WBU_SRC_LSU = 1'b1
  } wbu_src_e;

endpackage

// File: rtl/wbu_if.sv
// Writeback bus: issue port, EXU/LSU result handshakes, register-file write
// port, scoreboard and error status.
interface wbu_if #(
  parameter int unsigned DATA_WIDTH = wbu_pkg::WBU_DATA_W
);
  import wbu_pkg::*;

  logic                      i_wbu_iss_en;
  logic [GPRS_WIDTH-1:0]     i_wbu_iss_id;
  logic [NUM_GPRS-1:0]       o_wbu_busy;

  logic                      i_wbu_exu_valid;
  logic                      o_wbu_exu_ready;
  logic [GPRS_WIDTH-1:0]     i_wbu_exu_id;
  logic [DATA_WIDTH-1:0]     i_wbu_exu_data;

  logic                      i_wbu_lsu_valid;
  logic                      o_wbu_lsu_ready;
  logic [GPRS_WIDTH-1:0]     i_wbu_lsu_id;
  logic [DATA_WIDTH-1:0]     i_wbu_lsu_data;
  logic [1:0]                i_wbu_lsu_size;
  logic                      i_wbu_lsu_uns;
  logic [1:0]                i_wbu_lsu_off;

  logic                      o_gpr_wr_en;
  logic [GPRS_WIDTH-1:0]     o_gpr_wr_id;
  logic [DATA_WIDTH-1:0]     o_gpr_wr_data;
  logic                      o_wbu_err;

  modport slave (
    input  i_wbu_iss_en, i_wbu_iss_id,
    input  i_wbu_exu_valid, i_wbu_exu_id, i_wbu_exu_data,
    input  i_wbu_lsu_valid, i_wbu_lsu_id, i_wbu_lsu_data,
    input  i_wbu_lsu_size, i_wbu_lsu_uns, i_wbu_lsu_off,
    output o_wbu_busy, o_wbu_exu_ready, o_wbu_lsu_ready,
    output o_gpr_wr_en, o_gpr_wr_id, o_gpr_wr_data, o_wbu_err
  );

  modport master (
    output i_wbu_iss_en, i_wbu_iss_id,
    output i_wbu_exu_valid, i_wbu_exu_id, i_wbu_exu_data,
    output i_wbu_lsu_valid, i_wbu_lsu_id, i_wbu_lsu_data,
    output i_wbu_lsu_size, i_wbu_lsu_uns, i_wbu_lsu_off,
    input  o_wbu_busy, o_wbu_exu_ready, o_wbu_lsu_ready,
    input  o_gpr_wr_en, o_gpr_wr_id, o_gpr_wr_data, o_wbu_err
  );

endinterface

// File: rtl/wbu_ldfmt.sv
// Load formatter: extracts the addressed byte/half from an aligned memory word
// and sign- or zero-extends it. Purely combinational.
module wbu_ldfmt
  import wbu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WBU_DATA_W
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_size,
  input  logic                  i_uns,
  input  logic [1:0]            i_off,
  output logic [DATA_WIDTH-1:0] o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_data[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_data[31:16] : i_data[15:0];
  end

  // Size 3 is unencoded and falls through to the word path.
  always_comb begin
    o_data_c = i_data;
    case (i_size)
      LSU_SIZE_B: o_data_c = {{(DATA_WIDTH-8){~i_uns & w_byte[7]}}, w_byte};
      LSU_SIZE_H: o_data_c = {{(DATA_WIDTH-16){~i_uns & w_half[15]}}, w_half};
      default:    o_data_c = i_data;
    endcase
  end

endmodule

// File: rtl/wbu.sv
// Writeback unit: round-robin EXU/LSU arbiter, registered register-file write
// port, per-register pending-write scoreboard and sticky protocol error.
module wbu
  import wbu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WBU_DATA_W
) (
  input  logic  i_sys_clk,
  input  logic  i_sys_rst_n,
  wbu_if.slave  bus
);

  wbu_src_e                r_last;
  logic                    r_wr_en;
  logic [GPRS_WIDTH-1:0]   r_wr_id;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [NUM_GPRS-1:0]     r_busy;
  logic                    r_err;

  logic                    w_exu_ready;
  logic                    w_lsu_ready;
  logic                    w_exu_xfer;
  logic                    w_lsu_xfer;
  logic                    w_xfer;
  logic [GPRS_WIDTH-1:0]   w_win_id;
  logic [DATA_WIDTH-1:0]   w_win_data;
  logic [DATA_WIDTH-1:0]   w_ld_data;
  logic [NUM_GPRS-1:0]     w_clr_mask;
  logic [NUM_GPRS-1:0]     w_set_mask;
  logic [NUM_GPRS-1:0]     w_busy_nxt;
  logic                    w_win_busy;
  logic                    w_err_evt;

  wbu_ldfmt #(.DATA_WIDTH(DATA_WIDTH)) u_ldfmt (
    .i_data   (bus.i_wbu_lsu_data),
    .i_size   (bus.i_wbu_lsu_size),
    .i_uns    (bus.i_wbu_lsu_uns),
    .i_off    (bus.i_wbu_lsu_off),
    .o_data_c (w_ld_data)
  );

  // Grant: a lone valid wins; on conflict the source that did not win last goes.
  assign w_exu_ready = bus.i_wbu_exu_valid &&
                       (!bus.i_wbu_lsu_valid || (r_last == WBU_SRC_LSU));
  assign w_lsu_ready = bus.i_wbu_lsu_valid &&
                       (!bus.i_wbu_exu_valid || (r_last == WBU_SRC_EXU));
  assign w_exu_xfer  = bus.i_wbu_exu_valid && w_exu_ready;
  assign w_lsu_xfer  = bus.i_wbu_lsu_valid && w_lsu_ready;
  assign w_xfer      = w_exu_xfer || w_lsu_xfer;

  assign w_win_id    = w_lsu_xfer ? bus.i_wbu_lsu_id : bus.i_wbu_exu_id;
  assign w_win_data  = w_lsu_xfer ? w_ld_data        : bus.i_wbu_exu_data;

  assign w_clr_mask  = r_wr_en ? (NUM_GPRS'(1) << r_wr_id) : '0;
  assign w_set_mask  = (bus.i_wbu_iss_en && (bus.i_wbu_iss_id != '0)) ?
                       (NUM_GPRS'(1) << bus.i_wbu_iss_id) : '0;
  assign w_busy_nxt  = ((r_busy & ~w_clr_mask) | w_set_mask) & ~NUM_GPRS'(1);

  // The commit on this edge clears the bit, so a transfer to that id sees it idle.
  assign w_win_busy  = r_busy[w_win_id] && !(r_wr_en && (r_wr_id == w_win_id));
  assign w_err_evt   = w_xfer && (w_win_id != '0) && !w_win_busy;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_last    <= WBU_SRC_LSU;
      r_wr_en   <= 1'b0;
      r_wr_id   <= '0;
      r_wr_data <= '0;
      r_busy    <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_lsu_xfer) begin
        r_last <= WBU_SRC_LSU;
      end else if (w_exu_xfer) begin
        r_last <= WBU_SRC_EXU;
      end
      r_wr_en <= w_xfer && (w_win_id != '0);
      if (w_xfer) begin
        r_wr_id   <= w_win_id;
        r_wr_data <= w_win_data;
      end
      r_busy <= w_busy_nxt;
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.o_wbu_exu_ready = w_exu_ready;
  assign bus.o_wbu_lsu_ready = w_lsu_ready;
  assign bus.o_wbu_busy      = r_busy;
  assign bus.o_gpr_wr_en     = r_wr_en;
  assign bus.o_gpr_wr_id     = r_wr_id;
  assign bus.o_gpr_wr_data   = r_wr_data;
  assign bus.o_wbu_err       = r_err;

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: load-format vector table plus hand-written sequences
// for arbitration, scoreboard edge cases, error flag and asynchronous reset.
module tb_wbu;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wbu_if bus ();

  wbu u_dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .bus         (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] id);
    bus.i_wbu_iss_en = 1'b1;
    bus.i_wbu_iss_id = id;
    tick();
    bus.i_wbu_iss_en = 1'b0;
    bus.i_wbu_iss_id = '0;
  endtask

  task automatic exu_send(input logic [4:0] id, input logic [31:0] data);
    bus.i_wbu_exu_valid = 1'b1;
    bus.i_wbu_exu_id    = id;
    bus.i_wbu_exu_data  = data;
    #1;
    check("exu_ready", 32'(bus.o_wbu_exu_ready), 32'd1);
    tick();
    bus.i_wbu_exu_valid = 1'b0;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.i_wbu_iss_en    = 1'b0;
    bus.i_wbu_iss_id    = '0;
    bus.i_wbu_exu_valid = 1'b0;
    bus.i_wbu_exu_id    = '0;
    bus.i_wbu_exu_data  = '0;
    bus.i_wbu_lsu_valid = 1'b0;
    bus.i_wbu_lsu_id    = '0;
    bus.i_wbu_lsu_data  = '0;
    bus.i_wbu_lsu_size  = 2'd2;
    bus.i_wbu_lsu_uns   = 1'b0;
    bus.i_wbu_lsu_off   = 2'd0;

    vecs[0] = '{32'h8070_FF80, 2'd0, 1'b0, 2'd0, 32'hFFFF_FF80};
    vecs[1] = '{32'h8070_FF80, 2'd0, 1'b1, 2'd0, 32'h0000_0080};
    vecs[2] = '{32'h8070_FF80, 2'd1, 1'b0, 2'd2, 32'hFFFF_8070};
    vecs[3] = '{32'h8070_FF80, 2'd0, 1'b1, 2'd1, 32'h0000_00FF};
    vecs[4] = '{32'h8070_FF80, 2'd1, 1'b1, 2'd0, 32'h0000_FF80};
    vecs[5] = '{32'h8070_FF80, 2'd1, 1'b0, 2'd3, 32'hFFFF_8070};
    vecs[6] = '{32'h8070_FF80, 2'd2, 1'b0, 2'd1, 32'h8070_FF80};
    vecs[7] = '{32'h8070_FF80, 2'd3, 1'b1, 2'd2, 32'h8070_FF80};
    vecs[8] = '{32'h8070_FF80, 2'd0, 1'b0, 2'd3, 32'hFFFF_FF80};
    vecs[9] = '{32'h8070_FF80, 2'd0, 1'b0, 2'd2, 32'h0000_0070};

    // Reset state
    tick();
    tick();
    check("rst_wr_en",   32'(bus.o_gpr_wr_en),   32'd0);
    check("rst_wr_id",   32'(bus.o_gpr_wr_id),   32'd0);
    check("rst_wr_data", bus.o_gpr_wr_data,      32'd0);
    check("rst_busy",    bus.o_wbu_busy,         32'd0);
    check("rst_err",     32'(bus.o_wbu_err),     32'd0);
    rst_n = 1'b1;
    tick();

    // Dual contention straight out of reset: EXU first, then LSU
    issue(5'd3);
    issue(5'd4);
    check("dual_busy", bus.o_wbu_busy, 32'h0000_0018);
    bus.i_wbu_exu_valid = 1'b1;
    bus.i_wbu_exu_id    = 5'd3;
    bus.i_wbu_exu_data  = 32'h1;
    bus.i_wbu_lsu_valid = 1'b1;
    bus.i_wbu_lsu_id    = 5'd4;
    bus.i_wbu_lsu_data  = 32'h2;
    bus.i_wbu_lsu_size  = 2'd2;
    #1;
    check("dual_exu_ready0", 32'(bus.o_wbu_exu_ready), 32'd1);
    check("dual_lsu_ready0", 32'(bus.o_wbu_lsu_ready), 32'd0);
    tick();
    check("dual_wr_en0",     32'(bus.o_gpr_wr_en),     32'd1);
    check("dual_wr_id0",     32'(bus.o_gpr_wr_id),     32'd3);
    check("dual_wr_data0",   bus.o_gpr_wr_data,        32'h1);
    check("dual_exu_ready1", 32'(bus.o_wbu_exu_ready), 32'd0);
    check("dual_lsu_ready1", 32'(bus.o_wbu_lsu_ready), 32'd1);
    tick();
    bus.i_wbu_exu_valid = 1'b0;
    bus.i_wbu_lsu_valid = 1'b0;
    check("dual_wr_en1",     32'(bus.o_gpr_wr_en),     32'd1);
    check("dual_wr_id1",     32'(bus.o_gpr_wr_id),     32'd4);
    check("dual_wr_data1",   bus.o_gpr_wr_data,        32'h2);
    tick();
    check("dual_busy_clr",   bus.o_wbu_busy,           32'd0);
    check("dual_err",        32'(bus.o_wbu_err),       32'd0);

    // Single EXU write with one-cycle commit latency
    issue(5'd5);
    check("exu_busy_set", 32'(bus.o_wbu_busy[5]), 32'd1);
    exu_send(5'd5, 32'hDEAD_BEEF);
    check("exu_wr_en",    32'(bus.o_gpr_wr_en), 32'd1);
    check("exu_wr_id",    32'(bus.o_gpr_wr_id), 32'd5);
    check("exu_wr_data",  bus.o_gpr_wr_data,    32'hDEAD_BEEF);
    check("exu_busy_hold", 32'(bus.o_wbu_busy[5]), 32'd1);
    tick();
    check("exu_busy_clr", 32'(bus.o_wbu_busy[5]), 32'd0);
    check("exu_wr_en_off", 32'(bus.o_gpr_wr_en), 32'd0);

    // Load format table through the LSU path
    for (int i = 0; i < 10; i++) begin
      issue(5'd10);
      bus.i_wbu_lsu_valid = 1'b1;
      bus.i_wbu_lsu_id    = 5'd10;
      bus.i_wbu_lsu_data  = vecs[i].data;
      bus.i_wbu_lsu_size  = vecs[i].size;
      bus.i_wbu_lsu_uns   = vecs[i].uns;
      bus.i_wbu_lsu_off   = vecs[i].off;
      #1;
      check($sformatf("ld%0d_ready", i), 32'(bus.o_wbu_lsu_ready), 32'd1);
      tick();
      bus.i_wbu_lsu_valid = 1'b0;
      check($sformatf("ld%0d_wr_en", i), 32'(bus.o_gpr_wr_en), 32'd1);
      check($sformatf("ld%0d_data", i),  bus.o_gpr_wr_data,    vecs[i].exp);
      tick();
      check($sformatf("ld%0d_busy", i),  bus.o_wbu_busy,       32'd0);
    end

    // Write to x0: handshake completes, no register write, no error
    exu_send(5'd0, 32'h55);
    check("x0_wr_en", 32'(bus.o_gpr_wr_en), 32'd0);
    check("x0_err",   32'(bus.o_wbu_err),   32'd0);
    issue(5'd0);
    check("x0_busy",  bus.o_wbu_busy,       32'd0);

    // Issue to x7 on the edge its previous write commits: set wins
    issue(5'd7);
    exu_send(5'd7, 32'h77);
    check("same_wr_en", 32'(bus.o_gpr_wr_en), 32'd1);
    issue(5'd7);
    check("same_busy7", 32'(bus.o_wbu_busy[7]), 32'd1);
    check("same_err",   32'(bus.o_wbu_err),     32'd0);

    // Transfer to a non-pending register raises the sticky error
    check("err_pre", 32'(bus.o_wbu_err), 32'd0);
    exu_send(5'd9, 32'h99);
    check("err_set",   32'(bus.o_wbu_err),   32'd1);
    check("err_wr_en", 32'(bus.o_gpr_wr_en), 32'd1);
    tick();
    tick();
    check("err_hold",  32'(bus.o_wbu_err),   32'd1);

    // Asynchronous reset mid-stream with x4..x7 pending
    issue(5'd4);
    issue(5'd5);
    issue(5'd6);
    check("rst2_busy_pre", bus.o_wbu_busy, 32'h0000_00F0);
    exu_send(5'd4, 32'hA5A5_0001);
    check("rst2_wr_en_pre", 32'(bus.o_gpr_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst2_wr_en",   32'(bus.o_gpr_wr_en),   32'd0);
    check("rst2_wr_id",   32'(bus.o_gpr_wr_id),   32'd0);
    check("rst2_wr_data", bus.o_gpr_wr_data,      32'd0);
    check("rst2_busy",    bus.o_wbu_busy,         32'd0);
    check("rst2_err",     32'(bus.o_wbu_err),     32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst2_busy_post", bus.o_wbu_busy,       32'd0);
    check("rst2_err_post",  32'(bus.o_wbu_err),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
